// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the MEM pipeline stage
// Contents: FSM state enum, ResultSrc encodings, default load-response timeout.
package mem_pkg;
   typedef enum logic {IDLE, WAIT_RSP} state_t;
   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;
   localparam int RSP_TIMEOUT_DEF = 16;
endpackage

// File: rtl/mem_rsp_timer.sv
// mem_rsp_timer: clear/enable wait-cycle counter with timeout flag
// Ports: clk, rst (sync, active-high); i_clr restarts the count; i_en counts one wait cycle;
//        o_expired marks the RSP_TIMEOUT-th wait cycle.
module mem_rsp_timer
   import mem_pkg::*;
#(
   parameter int RSP_TIMEOUT = RSP_TIMEOUT_DEF,
   parameter int TMR_W       = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);
   logic [TMR_W-1:0] r_cnt;
   // r_cnt holds the wait cycles already elapsed, so the current cycle is number r_cnt+1
   assign o_expired = r_cnt == TMR_W'(RSP_TIMEOUT - 1);
   always_ff @(posedge clk) begin
      if (rst || i_clr) r_cnt <= '0;
      else if (i_en && !o_expired) r_cnt <= r_cnt + 1'b1;
   end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: RISC-V MEM stage with valid/ready data-memory port and MEM/WB register
// Ports: EX/MEM inputs (*M); dmem request (valid/ready, we, addr, wdata) and load response
//        (rsp_valid, rsp_rdata); StallM to the hazard unit; MEM/WB outputs (*W);
//        bus_err sticky load-timeout flag; misalign_err one-cycle pulse.
// Build option: MEM_ALIGN_CHECK_EN drops misaligned accesses as bubbles and pulses misalign_err;
//        without it the address is word-aligned and misalign_err is tied low.
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int RSP_TIMEOUT = RSP_TIMEOUT_DEF,
   parameter int TMR_W       = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic        MemReadM,
   input  logic [1:0]  ResultSrcM,
   input  logic [4:0]  RdM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] PCPlus4M,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_rsp_valid,
   input  logic [31:0] dmem_rsp_rdata,
   output logic        StallM,
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcW,
   output logic [4:0]  RdW,
   output logic [31:0] ALUResultW,
   output logic [31:0] ReadDataW,
   output logic [31:0] PCPlus4W,
   output logic        bus_err,
   output logic        misalign_err
);
   state_t r_state, w_next;
   logic   w_op, w_wait, w_mis, w_req, w_accept_ld, w_rsp, w_timeout, w_expired;
   assign w_op   = MemReadM | MemWriteM;
   assign w_wait = r_state == WAIT_RSP;
`ifdef MEM_ALIGN_CHECK_EN
   logic r_misalign;
   assign w_mis        = !w_wait && w_op && (ALUResultM[1:0] != 2'b00);
   assign dmem_addr    = ALUResultM;
   assign misalign_err = r_misalign;
   always_ff @(posedge clk) r_misalign <= rst ? 1'b0 : w_mis;
`else
   assign w_mis        = 1'b0;
   assign dmem_addr    = {ALUResultM[31:2], 2'b00};
   assign misalign_err = 1'b0;
`endif
   // MemWriteM wins when both read and write are flagged
   assign dmem_we        = MemWriteM;
   assign dmem_wdata     = WriteDataM;
   assign dmem_req_valid = w_req;
   always_comb begin
      w_req       = !w_wait && w_op && !w_mis;
      w_accept_ld = w_req && dmem_req_ready && !MemWriteM;
      w_rsp       = w_wait && dmem_rsp_valid;
      w_timeout   = w_wait && !dmem_rsp_valid && w_expired;
      StallM      = w_wait ? !(w_rsp || w_timeout) : (w_req && (!dmem_req_ready || !MemWriteM));
      w_next      = w_accept_ld ? WAIT_RSP : (w_rsp || w_timeout) ? IDLE : r_state;
   end
   mem_rsp_timer #(.RSP_TIMEOUT(RSP_TIMEOUT), .TMR_W(TMR_W)) u_tmr (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_accept_ld),
      .i_en     (w_wait),
      .o_expired(w_expired)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         bus_err    <= 1'b0;
         RegWriteW  <= 1'b0;
         ResultSrcW <= '0;
         RdW        <= '0;
         ALUResultW <= '0;
         ReadDataW  <= '0;
         PCPlus4W   <= '0;
      end else begin
         r_state <= w_next;
         if (w_timeout) bus_err <= 1'b1;
         // a stalled cycle inserts a bubble; the other fields simply hold
         if (StallM) RegWriteW <= 1'b0;
         else begin
            RegWriteW  <= RegWriteM && !w_mis;
            ResultSrcW <= ResultSrcM;
            RdW        <= RdM;
            ALUResultW <= ALUResultM;
            PCPlus4W   <= PCPlus4M;
            if (w_wait) ReadDataW <= w_rsp ? dmem_rsp_rdata : '0;
         end
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
   import mem_pkg::*;
   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteM, MemWriteM, MemReadM;
   logic [1:0]  ResultSrcM;
   logic [4:0]  RdM;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   logic        dmem_req_valid, dmem_req_ready, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rsp_rdata;
   logic        StallM, RegWriteW;
   logic [1:0]  ResultSrcW;
   logic [4:0]  RdW;
   logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
   logic        bus_err, misalign_err;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.RSP_TIMEOUT(16), .TMR_W(5)) dut (
      .clk(clk), .rst(rst),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
      .ResultSrcM(ResultSrcM), .RdM(RdM), .ALUResultM(ALUResultM),
      .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
      .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
      .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
      .bus_err(bus_err), .misalign_err(misalign_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      RegWriteM = 0; MemWriteM = 0; MemReadM = 0; ResultSrcM = RES_ALU; RdM = 0;
      ALUResultM = 0; WriteDataM = 0; PCPlus4M = 0;
      dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_rdata = 0;
   endtask

   task automatic test_reset();
      rst = 1; idle_inputs();
      tick(); tick();
      rst = 0; #1;
      checks++; if ({RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W} !== '0) begin errors++; $display("FAIL reset_memwb: got %0h expected 0", {RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W}); end
      checks++; if ({bus_err, misalign_err, dmem_req_valid, StallM} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {bus_err, misalign_err, dmem_req_valid, StallM}); end
   endtask

   task automatic test_alu();
      RegWriteM = 1; RdM = 5; ALUResultM = 32'h10; PCPlus4M = 32'h24; ResultSrcM = RES_ALU; #1;
      checks++; if ({dmem_req_valid, StallM} !== 2'b00) begin errors++; $display("FAIL alu_noreq: got %b expected 00", {dmem_req_valid, StallM}); end
      tick();
      checks++; if ({RegWriteW, RdW, ALUResultW, PCPlus4W} !== {1'b1, 5'd5, 32'h10, 32'h24}) begin errors++; $display("FAIL alu_wb: got %0h expected %0h", {RegWriteW, RdW, ALUResultW, PCPlus4W}, {1'b1, 5'd5, 32'h10, 32'h24}); end
      idle_inputs();
   endtask

   task automatic test_store_wait();
      int n_req = 0, n_stall = 0;
      MemWriteM = 1; ALUResultM = 32'h100; WriteDataM = 32'hDEADBEEF; RdM = 3;
      for (int i = 0; i < 3; i++) begin
         dmem_req_ready = (i == 2); #1;
         n_req += int'(dmem_req_valid); n_stall += int'(StallM);
         checks++; if ({dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 32'h100, 32'hDEADBEEF}) begin errors++; $display("FAIL store_req[%0d]: got %0h expected %0h", i, {dmem_we, dmem_addr, dmem_wdata}, {1'b1, 32'h100, 32'hDEADBEEF}); end
         tick();
      end
      checks++; if (n_req !== 3) begin errors++; $display("FAIL store_valid_cycles: got %0d expected 3", n_req); end
      checks++; if (n_stall !== 2) begin errors++; $display("FAIL store_stall_cycles: got %0d expected 2", n_stall); end
      checks++; if ({RegWriteW, RdW, ALUResultW} !== {1'b0, 5'd3, 32'h100}) begin errors++; $display("FAIL store_wb: got %0h expected %0h", {RegWriteW, RdW, ALUResultW}, {1'b0, 5'd3, 32'h100}); end
      idle_inputs();
   endtask

   task automatic test_load();
      int n_stall = 0;
      MemReadM = 1; RegWriteM = 1; ResultSrcM = RES_MEM; RdM = 7; ALUResultM = 32'h40; dmem_req_ready = 1; #1;
      checks++; if ({dmem_req_valid, dmem_we, dmem_addr} !== {1'b1, 1'b0, 32'h40}) begin errors++; $display("FAIL load_req: got %0h expected %0h", {dmem_req_valid, dmem_we, dmem_addr}, {1'b1, 1'b0, 32'h40}); end
      for (int i = 0; i < 4; i++) begin
         dmem_rsp_valid = (i == 3); dmem_rsp_rdata = (i == 3) ? 32'h12345678 : 32'hBAD0BAD0; #1;
         n_stall += int'(StallM);
         if (i == 1) begin
            checks++; if ({dmem_req_valid, RegWriteW} !== 2'b00) begin errors++; $display("FAIL load_wait_bubble: got %b expected 00", {dmem_req_valid, RegWriteW}); end
         end
         tick();
         dmem_req_ready = 0;
      end
      checks++; if (n_stall !== 3) begin errors++; $display("FAIL load_stall_cycles: got %0d expected 3", n_stall); end
      checks++; if ({ReadDataW, RegWriteW, ResultSrcW, RdW} !== {32'h12345678, 1'b1, 2'b01, 5'd7}) begin errors++; $display("FAIL load_wb: got %0h expected %0h", {ReadDataW, RegWriteW, ResultSrcW, RdW}, {32'h12345678, 1'b1, 2'b01, 5'd7}); end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      MemWriteM = 1; ALUResultM = 32'h200; WriteDataM = 32'h55; dmem_req_ready = 1; #1;
      checks++; if ({dmem_req_valid, StallM} !== 2'b10) begin errors++; $display("FAIL b2b_store: got %b expected 10", {dmem_req_valid, StallM}); end
      tick();
      idle_inputs(); RegWriteM = 1; RdM = 9; ALUResultM = 32'h77; #1;
      checks++; if ({RegWriteW, ALUResultW, StallM} !== {1'b0, 32'h200, 1'b0}) begin errors++; $display("FAIL b2b_store_wb: got %0h expected %0h", {RegWriteW, ALUResultW, StallM}, {1'b0, 32'h200, 1'b0}); end
      tick();
      checks++; if ({RegWriteW, RdW, ALUResultW} !== {1'b1, 5'd9, 32'h77}) begin errors++; $display("FAIL b2b_alu_wb: got %0h expected %0h", {RegWriteW, RdW, ALUResultW}, {1'b1, 5'd9, 32'h77}); end
      idle_inputs();
   endtask

   task automatic test_timeout();
      int n_stall = 0;
      bit done = 0;
      MemReadM = 1; RegWriteM = 1; ResultSrcM = RES_MEM; RdM = 11; ALUResultM = 32'h80; dmem_req_ready = 1;
      dmem_rsp_rdata = 32'hFFFF_FFFF; #1;
      for (int i = 0; i < 40 && !done; i++) begin
         if (StallM) n_stall++;
         else begin
            done = 1;
            checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL timeout_early_err: got %b expected 0", bus_err); end
         end
         tick();
         dmem_req_ready = 0; #1;
      end
      checks++; if (!done) begin errors++; $display("FAIL timeout_bound: got no completion expected completion within 40 cycles"); end
      checks++; if (n_stall !== 16) begin errors++; $display("FAIL timeout_stall_cycles: got %0d expected 16", n_stall); end
      checks++; if ({ReadDataW, RegWriteW, RdW, bus_err} !== {32'h0, 1'b1, 5'd11, 1'b1}) begin errors++; $display("FAIL timeout_wb: got %0h expected %0h", {ReadDataW, RegWriteW, RdW, bus_err}, {32'h0, 1'b1, 5'd11, 1'b1}); end
      idle_inputs();
      repeat (3) tick();
      checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", bus_err); end
   endtask

   task automatic test_rst_mid_wait();
      MemReadM = 1; RegWriteM = 1; ResultSrcM = RES_MEM; RdM = 4; ALUResultM = 32'h60; dmem_req_ready = 1;
      tick();
      dmem_req_ready = 0;
      tick();
      rst = 1; tick(); rst = 0;
      idle_inputs(); #1;
      checks++; if ({RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W, bus_err, misalign_err, dmem_req_valid, StallM} !== '0) begin errors++; $display("FAIL rst_mid_outputs: got %0h expected 0", {RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W, bus_err, misalign_err, dmem_req_valid, StallM}); end
      dmem_rsp_valid = 1; dmem_rsp_rdata = 32'hCAFEF00D; #1;
      checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL stale_rsp_stall: got %b expected 0", StallM); end
      tick();
      checks++; if ({RegWriteW, ReadDataW} !== {1'b0, 32'h0}) begin errors++; $display("FAIL stale_rsp_ignored: got %0h expected 0", {RegWriteW, ReadDataW}); end
      idle_inputs();
   endtask

   task automatic test_misalign();
      MemReadM = 1; RegWriteM = 1; ResultSrcM = RES_MEM; RdM = 6; ALUResultM = 32'h102; dmem_req_ready = 1; #1;
`ifdef MEM_ALIGN_CHECK_EN
      checks++; if ({dmem_req_valid, StallM} !== 2'b00) begin errors++; $display("FAIL misalign_noreq: got %b expected 00", {dmem_req_valid, StallM}); end
      tick();
      idle_inputs(); #1;
      checks++; if ({misalign_err, RegWriteW} !== 2'b10) begin errors++; $display("FAIL misalign_pulse: got %b expected 10", {misalign_err, RegWriteW}); end
      tick();
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL misalign_one_cycle: got %b expected 0", misalign_err); end
`else
      checks++; if ({dmem_req_valid, dmem_addr, misalign_err} !== {1'b1, 32'h100, 1'b0}) begin errors++; $display("FAIL misalign_forced: got %0h expected %0h", {dmem_req_valid, dmem_addr, misalign_err}, {1'b1, 32'h100, 1'b0}); end
      tick();
      dmem_req_ready = 0; dmem_rsp_valid = 1; dmem_rsp_rdata = 32'h0BADF00D;
      tick();
      checks++; if ({RegWriteW, ReadDataW, ALUResultW, misalign_err} !== {1'b1, 32'h0BADF00D, 32'h102, 1'b0}) begin errors++; $display("FAIL misalign_load_wb: got %0h expected %0h", {RegWriteW, ReadDataW, ALUResultW, misalign_err}, {1'b1, 32'h0BADF00D, 32'h102, 1'b0}); end
`endif
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_store_wait();
      test_load();
      test_back_to_back();
      test_timeout();
      test_rst_mid_wait();
      test_misalign();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
